// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 16x oversampling and a level ready/ack handshake.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse.
module uart_rx_oversampled #(
  parameter int CLOCK_RATE = 25000000,
  parameter int BAUD_RATE  = 57600,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  assign rx_s = sync[1];
  assign tick = (tick_cnt == TICK_LAST);

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  // Free-running oversample tick divider
  always_ff @(posedge Clock or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // Receive FSM with registered outputs and handshake
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      data_out    <= 8'h00;
      data_ready  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (data_ack && data_ready) data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_MID) begin
              sample_cnt <= '0;
              bit_cnt    <= 3'd0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_LAST) begin
              sample_cnt <= '0;
              shift      <= {rx_s, shift[7:1]};
              bit_cnt    <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_LAST) begin
              sample_cnt <= '0;
              par_bit    <= rx_s;
              state      <= STOP;
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_LAST) begin
              sample_cnt <= '0;
              if (rx_s) begin
                // A completing byte wins over a same-cycle ack
                data_out   <= shift;
                data_ready <= 1'b1;
                overrun    <= data_ready && !data_ack;
                state      <= IDLE;
                busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error <= ^{shift, par_bit};
`endif
              end else begin
                frame_error <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at TICK_DIV=1 (16 clocks per bit).
module tb_uart_rx_oversampled;

  logic       Clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  localparam bit WITH_PAR = 1'b1;
`else
  logic       parity_error;
  localparam bit WITH_PAR = 1'b0;
  assign parity_error = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int fe0, ov0, pe0;

  uart_rx_oversampled #(
    .CLOCK_RATE(1600000),
    .BAUD_RATE (100000),
    .OVERSAMPLE(16)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .rx          (rx),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy        (busy)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (frame_error)  fe_cnt++;
    if (overrun)      ov_cnt++;
    if (parity_error) pe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (16) @(posedge Clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (WITH_PAR) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic ack;
    data_ack = 1'b1;
    @(posedge Clock); #1;
    data_ack = 1'b0;
  endtask

  task automatic snap;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; data_ack = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge Clock);
    #1;

    // 1: clean byte, held until ack
    snap();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    check("t1_data", {24'd0, data_out}, 32'hA5);
    check("t1_ready", {31'd0, data_ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(posedge Clock);
    #1;
    check("t1_ready_held", {31'd0, data_ready}, 32'd1);
    check("t1_no_fe", fe_cnt - fe0, 32'd0);
    check("t1_no_ov", ov_cnt - ov0, 32'd0);
    check("t1_no_pe", pe_cnt - pe0, 32'd0);
    ack();
    check("t1_ack_clears", {31'd0, data_ready}, 32'd0);
    ack();
    check("t1_ack_idle", {31'd0, data_ready}, 32'd0);

    // 2: short glitch on the line
    rx = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    check("t2_busy_in_start", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (20) @(posedge Clock);
    #1;
    check("t2_busy_drop", {31'd0, busy}, 32'd0);
    check("t2_ready", {31'd0, data_ready}, 32'd0);

    // 3: framing error with line held low
    snap();
    send_frame(8'h5A, 1'b0, ^8'h5A);
    repeat (40) @(posedge Clock);
    #1;
    check("t3_fe_pulse", fe_cnt - fe0, 32'd1);
    check("t3_ready", {31'd0, data_ready}, 32'd0);
    check("t3_data_kept", {24'd0, data_out}, 32'hA5);
    check("t3_busy_low_line", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (5) @(posedge Clock);
    #1;
    check("t3_busy_released", {31'd0, busy}, 32'd0);
    check("t3_fe_single", fe_cnt - fe0, 32'd1);
    repeat (16) @(posedge Clock);
    #1;

    // 4: back-to-back bytes without ack
    snap();
    send_frame(8'h3C, 1'b1, ^8'h3C);
    check("t4_first", {24'd0, data_out}, 32'h3C);
    check("t4_first_no_ov", ov_cnt - ov0, 32'd0);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    check("t4_second", {24'd0, data_out}, 32'hC3);
    check("t4_ready", {31'd0, data_ready}, 32'd1);
    check("t4_overrun", ov_cnt - ov0, 32'd1);
    ack();

    // 5: reset mid-frame, then clean reception
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(posedge Clock);
    #1;
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_data", {24'd0, data_out}, 32'h00);
    check("t5_rst_ready", {31'd0, data_ready}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    reset = 1'b0;
    repeat (32) @(posedge Clock);
    #1;
    snap();
    send_frame(8'h11, 1'b1, ^8'h11);
    check("t5_data", {24'd0, data_out}, 32'h11);
    check("t5_ready", {31'd0, data_ready}, 32'd1);
    check("t5_no_fe", fe_cnt - fe0, 32'd0);
    ack();

`ifdef UART_RX_PARITY_EN
    // 6: parity checking
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    check("t6_data", {24'd0, data_out}, 32'h01);
    check("t6_pe_pulse", pe_cnt - pe0, 32'd1);
    ack();
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    check("t6_data_ok", {24'd0, data_out}, 32'h01);
    check("t6_no_pe", pe_cnt - pe0, 32'd0);
    ack();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
